// File: rtl/dac_pkg.sv
// Shared types, frame constants and the sample conversion helper for the DAC SPI transmitter.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP,
        LATCH
    } dac_state_t;

    localparam logic DAC_BUF    = 1'b1;
    localparam logic DAC_GA_N   = 1'b1;
    localparam logic DAC_SHDN_N = 1'b1;

    localparam int unsigned FRAME_BITS = 16;

    // Signed to offset binary: flip the sign bit, drop the 4 LSBs.
    function automatic logic [11:0] to_dac12(logic signed [15:0] s);
        return {~s[15], s[14:4]};
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Baud tick generator: one-cycle tick every SclkDiv clocks, held cleared while clear_i is high.
module dac_tick_gen #(
    parameter int unsigned SclkDiv = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (SclkDiv > 1) ? $clog2(SclkDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SclkDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = !clear_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI write stage for an MCP4922-class DAC with a one-deep pending sample buffer.
// Define DAC_LDAC_EN to add a LATCH state that pulses dac_ldac_n after each frame.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned clock_max   = 25_000_000,
    parameter int unsigned SCLK_DIV    = 2,
    parameter logic        DAC_CHANNEL = 1'b0
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic [15:0] audio_in,
    input  logic        data_ready,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        dac_cs_n,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        overrun
);

`ifdef DAC_LDAC_EN
    localparam dac_state_t LastSt   = LATCH;
    localparam logic       LdacIdle = 1'b1;
`else
    localparam dac_state_t LastSt   = CS_GAP;
    localparam logic       LdacIdle = 1'b0;
`endif

    localparam logic [3:0] CfgBits = {DAC_CHANNEL, DAC_BUF, DAC_GA_N, DAC_SHDN_N};

    dac_state_t  state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [11:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic        overrun_q, overrun_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        ldac_n_q, ldac_n_d;
    logic        busy_q, busy_d;
    logic        tick, frame_end, cs_active;
    logic [3:0]  unused_lsb;

    assign unused_lsb = audio_in[3:0];

    dac_tick_gen #(
        .SclkDiv(SCLK_DIV)
    ) u_tick (
        .clk_i  (clk_25mhz),
        .rst_ni (reset),
        .clear_i(state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = 1'b0;
        frame_end    = tick && (state_q == LastSt);

        if (tick) begin
            case (state_q)
                CS_SETUP: begin
                    state_d   = SHIFT;
                    phase_d   = 1'b1;
                    bit_cnt_d = 4'(FRAME_BITS - 1);
                end
                SHIFT: begin
                    // Data advances on the falling SCLK edge; the DAC samples on the rising one.
                    if (phase_q) begin
                        phase_d = 1'b0;
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bit_cnt_q == 4'd0) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        phase_d   = 1'b1;
                    end
                end
                CS_HOLD: state_d = CS_GAP;
                CS_GAP:  state_d = (LastSt == CS_GAP) ? IDLE : LATCH;
                LATCH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (frame_end) begin
            if (data_ready) begin
                state_d      = CS_SETUP;
                shreg_d      = {CfgBits, to_dac12(audio_in)};
                overrun_d    = pend_valid_q;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                state_d      = CS_SETUP;
                shreg_d      = {CfgBits, pend_q};
                pend_valid_d = 1'b0;
            end
        end else if (data_ready) begin
            if (state_q == IDLE) begin
                state_d = CS_SETUP;
                shreg_d = {CfgBits, to_dac12(audio_in)};
            end else begin
                pend_d       = to_dac12(audio_in);
                pend_valid_d = 1'b1;
                overrun_d    = pend_valid_q;
            end
        end

        // Outputs are registered from next-state values so they align with state_q.
        cs_active = (state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD);
        cs_n_d    = !cs_active;
        sclk_d    = (state_d == SHIFT) && phase_d;
        mosi_d    = cs_active && shreg_d[15];
        ldac_n_d  = (state_d == LATCH) ? 1'b0 : LdacIdle;
        busy_d    = (state_d != IDLE) || pend_valid_d;
    end

    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            ldac_n_q     <= LdacIdle;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            ldac_n_q     <= ldac_n_d;
            busy_q       <= busy_d;
        end
    end

    // MCP4922 SCLK limit is 20 MHz.
    always_ff @(posedge clk_25mhz) begin
        assert (SCLK_DIV >= 1 && clock_max / (2 * SCLK_DIV) <= 20_000_000);
    end

    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
